// File: rtl/md_issue_ctrl.sv
// EX-stage issue controller for the multiply/divide unit: drives and holds the MD
// operation/operands, stalls MD-class instructions while the unit is occupied, returns mfhi/mflo data.
//
// state | meaning
// IDLE  | no MD access in progress, IDLE_OP driven
// START | mult/div presented, MD unit latches start at closing edge
// WAIT  | op/operands held while MD unit is busy, watchdog counting
// WRITE | mthi/mtlo presented for one cycle
// READ  | mfhi/mflo presented, result captured at closing edge
module md_issue_ctrl #(
  parameter int          TIMEOUT = 32,
  parameter logic [4:0]  IDLE_OP = 5'b00000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EXValid,
  input  logic [4:0]  EXMDOp,
  input  logic [31:0] EXOperand1,
  input  logic [31:0] EXOperand2,
  input  logic        Flush,
  input  logic        MDBusy,
  input  logic [31:0] MDResult,
  output logic [4:0]  MDOperation,
  output logic [31:0] MDOperand1,
  output logic [31:0] MDOperand2,
  output logic        Stall,
  output logic [31:0] ResultOut,
  output logic        ResultValid,
  output logic        MDError
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_WRITE,
    S_READ
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      mdop_q, mdop_d;
  logic [31:0]     opnd1_q, opnd1_d;
  logic [31:0]     opnd2_q, opnd2_d;
  logic [31:0]     result_q, result_d;
  logic            rvalid_q, rvalid_d;
  logic            error_q, error_d;
  logic [WDW-1:0]  wdog_q, wdog_d;

  logic is_md;
  logic stall;
  logic accept;

  assign is_md  = (EXMDOp >= 5'd5) && (EXMDOp <= 5'd12);
  // MDBusy term protects against a reset that landed while the (unreset) MD unit was mid-operation
  assign stall  = EXValid && is_md && ((state_q != S_IDLE) || MDBusy);
  assign accept = EXValid && is_md && !stall && !Flush;

  always_comb begin
    state_d  = state_q;
    mdop_d   = mdop_q;
    opnd1_d  = opnd1_q;
    opnd2_d  = opnd2_q;
    result_d = result_q;
    rvalid_d = 1'b0;
    error_d  = error_q;
    wdog_d   = wdog_q;

    case (state_q)
      S_IDLE: begin
        mdop_d = IDLE_OP;
        if (accept) begin
          mdop_d = EXMDOp;
          case (EXMDOp)
            5'd5, 5'd6, 5'd7, 5'd8: begin
              opnd1_d = EXOperand1;
              opnd2_d = EXOperand2;
              state_d = S_START;
            end
            5'd11, 5'd12: begin
              opnd1_d = EXOperand1;
              opnd2_d = '0;
              state_d = S_WRITE;
            end
            default: state_d = S_READ;
          endcase
        end
      end
      S_START: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // hi/lo are recomputed from the inputs, so op and operands stay put until done
        if (!MDBusy) begin
          mdop_d  = IDLE_OP;
          state_d = S_IDLE;
        end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
          wdog_d  = wdog_q + WDW'(1);
          error_d = 1'b1;
          mdop_d  = IDLE_OP;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      S_WRITE: begin
        mdop_d  = IDLE_OP;
        state_d = S_IDLE;
      end
      S_READ: begin
        result_d = MDResult;
        rvalid_d = !Flush;
        mdop_d   = IDLE_OP;
        state_d  = S_IDLE;
      end
      default: begin
        mdop_d  = IDLE_OP;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      mdop_q   <= IDLE_OP;
      opnd1_q  <= '0;
      opnd2_q  <= '0;
      result_q <= '0;
      rvalid_q <= 1'b0;
      error_q  <= 1'b0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      mdop_q   <= mdop_d;
      opnd1_q  <= opnd1_d;
      opnd2_q  <= opnd2_d;
      result_q <= result_d;
      rvalid_q <= rvalid_d;
      error_q  <= error_d;
      wdog_q   <= wdog_d;
    end
  end

  assign MDOperation = mdop_q;
  assign MDOperand1  = opnd1_q;
  assign MDOperand2  = opnd2_q;
  assign Stall       = stall;
  assign ResultOut   = result_q;
  assign ResultValid = rvalid_q;
  assign MDError     = error_q;

endmodule
